// File: rtl/data_trans_mux.sv
// Ping-pong sample buffer: ADC A/B pairs fill one half while the USB side reads the other.
// Optional build macro DTM_TEST_PATTERN_EN replaces ADC data with an internal counter pattern.
module data_trans_mux #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ad7266dataa,
  input  logic [DATA_W-1:0] ad7266datab,
  input  logic              ad7266wren,
  input  logic [ADDR_W-1:0] usbdadd,
  output logic [DATA_W-1:0] usbdata,
  output logic              send_go
);

  localparam int PTR_W = ADDR_W - 1;

  // Even bank holds channel A words, odd bank channel B; index is {half, pair}.
  logic [DATA_W-1:0] mem_a [2**ADDR_W];
  logic [DATA_W-1:0] mem_b [2**ADDR_W];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic              wsel_q, wsel_d;
  logic              wrap_q, wrap_d;
  logic              send_go_q, send_go_d;
  logic [DATA_W-1:0] usbdata_q, usbdata_d;
  logic [DATA_W-1:0] wr_a, wr_b;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;

`ifdef DTM_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat_q, pat_d;

  always_comb begin
    wr_a  = pat_q;
    wr_b  = pat_q + DATA_W'(1);
    pat_d = pat_q;
    if (ad7266wren) begin
      pat_d = pat_q + DATA_W'(2);
    end else begin
      pat_d = pat_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= {DATA_W{1'b0}};
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  always_comb begin
    wr_a = ad7266dataa;
    wr_b = ad7266datab;
  end
`endif

  always_comb begin
    wr_idx    = {wsel_q, wptr_q};
    rd_idx    = {~wsel_q, usbdadd[ADDR_W-1:1]};
    usbdata_d = mem_a[rd_idx];
    if (usbdadd[0]) begin
      usbdata_d = mem_b[rd_idx];
    end else begin
      usbdata_d = mem_a[rd_idx];
    end
    wptr_d = wptr_q;
    wrap_d = 1'b0;
    if (ad7266wren) begin
      wptr_d = wptr_q + PTR_W'(1);
      wrap_d = (wptr_q == {PTR_W{1'b1}});
    end else begin
      wptr_d = wptr_q;
      wrap_d = 1'b0;
    end
    wsel_d    = wsel_q ^ wrap_d;
    // The pulse trails the swap edge by one clock so the completed half is already selected.
    send_go_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (ad7266wren) begin
      mem_a[wr_idx] <= wr_a;
      mem_b[wr_idx] <= wr_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= {PTR_W{1'b0}};
      wsel_q    <= 1'b0;
      wrap_q    <= 1'b0;
      send_go_q <= 1'b0;
      usbdata_q <= {DATA_W{1'b0}};
    end else begin
      wptr_q    <= wptr_d;
      wsel_q    <= wsel_d;
      wrap_q    <= wrap_d;
      send_go_q <= send_go_d;
      usbdata_q <= usbdata_d;
    end
  end

  assign usbdata = usbdata_q;
  assign send_go = send_go_q;

endmodule

// File: tb/tb_data_trans_mux.sv
// Scoreboard bench for data_trans_mux with ADDR_W=4; honours DTM_TEST_PATTERN_EN when defined.
module tb_data_trans_mux;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ad7266dataa = 16'h0000;
  logic [DW-1:0] ad7266datab = 16'h0000;
  logic          ad7266wren = 1'b0;
  logic [AW-1:0] usbdadd = 4'h0;
  logic [DW-1:0] usbdata;
  logic          send_go;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [2][16];
  logic          model_wsel = 1'b0;
  int            model_wptr = 0;
  logic          model_wrap = 1'b0;
  logic [DW-1:0] model_pat  = 16'h0000;
  logic [DW-1:0] rd_q [$];
  logic          go_q [$];

  data_trans_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ad7266dataa(ad7266dataa), .ad7266datab(ad7266datab), .ad7266wren(ad7266wren),
    .usbdadd(usbdadd), .usbdata(usbdata), .send_go(send_go)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from pre-edge state, advance the model, compare after the edge.
  task automatic step(input bit do_rd);
    logic [DW-1:0] e;
    logic          g;
    logic [DW-1:0] wa, wb;
    e = rst ? 16'h0000 : model_mem[~model_wsel][usbdadd];
    g = model_wrap;
`ifdef DTM_TEST_PATTERN_EN
    wa = model_pat;
    wb = model_pat + 16'h0001;
`else
    wa = ad7266dataa;
    wb = ad7266datab;
`endif
    if (rst) begin
      model_wsel = 1'b0;
      model_wptr = 0;
      model_wrap = 1'b0;
      model_pat  = 16'h0000;
      g = 1'b0;
    end else if (ad7266wren) begin
      model_mem[model_wsel][2*model_wptr]   = wa;
      model_mem[model_wsel][2*model_wptr+1] = wb;
      model_pat = model_pat + 16'h0002;
      if (model_wptr == 7) begin
        model_wptr = 0;
        model_wsel = ~model_wsel;
        model_wrap = 1'b1;
      end else begin
        model_wptr++;
        model_wrap = 1'b0;
      end
    end else begin
      model_wrap = 1'b0;
    end
    if (do_rd) rd_q.push_back(e);
    go_q.push_back(g);
    @(posedge clk);
    #1;
    check_val("send_go", {31'd0, send_go}, {31'd0, go_q.pop_front()});
    if (do_rd) check_val($sformatf("usbdata@%0d", usbdadd), {16'd0, usbdata}, {16'd0, rd_q.pop_front()});
  endtask

  task automatic strobes(input int n, input logic [DW-1:0] base_a, input logic [DW-1:0] base_b,
                         input bit do_rd);
    for (int i = 0; i < n; i++) begin
      ad7266wren  = 1'b1;
      ad7266dataa = base_a + DW'(i);
      ad7266datab = base_b + DW'(i);
      if (do_rd) usbdadd = AW'(i);
      step(do_rd);
    end
    ad7266wren = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      usbdadd = AW'(a);
      step(1'b1);
    end
  endtask

  initial begin
    // Reset behaviour
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("rst_usbdata", {16'd0, usbdata}, 32'd0);
      check_val("rst_send_go", {31'd0, send_go}, 32'd0);
    end
    rst = 1'b0;
    repeat (4) step(1'b0);

    // First fill of half 0, then readback
    strobes(8, 16'h0001, 16'h1001, 1'b0);
    repeat (2) step(1'b0);
`ifndef DTM_TEST_PATTERN_EN
    for (int a = 0; a < 16; a++) begin
      logic [DW-1:0] want;
      want = (a % 2 == 0) ? DW'(16'h0001 + a/2) : DW'(16'h1001 + a/2);
      check_val("fixed_model", {16'd0, model_mem[0][a]}, {16'd0, want});
    end
`else
    for (int a = 0; a < 16; a++) begin
      check_val("pattern_model", {16'd0, model_mem[0][a]}, a);
    end
`endif
    read_all();

    // Continuous strobing for three halves with concurrent reads
    strobes(24, 16'h2000, 16'h3000, 1'b1);
    step(1'b0);
    read_all();

    // Read held at address 3 across the swap edge
    strobes(7, 16'h4000, 16'h5000, 1'b0);
    usbdadd = 4'h3;
    ad7266wren  = 1'b1;
    ad7266dataa = 16'h4007;
    ad7266datab = 16'h5007;
    step(1'b1);
    ad7266wren = 1'b0;
    step(1'b1);
    step(1'b1);

    // Reset mid-fill discards the partial half
    strobes(5, 16'h6000, 16'h7000, 1'b0);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    strobes(8, 16'h8000, 16'h9000, 1'b0);
    repeat (2) step(1'b0);
    read_all();

    // Reset coinciding with the last write suppresses send_go
    strobes(7, 16'hA000, 16'hB000, 1'b0);
    ad7266wren = 1'b1;
    rst = 1'b1;
    step(1'b0);
    ad7266wren = 1'b0;
    rst = 1'b0;
    repeat (3) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
